ir_nec_receiver: RTL and testbench

Decodes NEC-protocol infrared remote frames from a demodulated IR receiver output (idle high, mark = low) into an address and a data word. It validates the complemented copies and pulses `data_ready` when a frame is good. Sits between the IR sensor pin and the command logic, on a single slow system clock. All pulse timing is measured in clock ticks, scaled by parameters.

---
 rtl/ir_nec_pkg.sv | 34 +++
 rtl/ir_sync_edge.sv | 22 ++
 rtl/ir_nec_receiver.sv | 175 +++++++++++++++++
 tb/tb_ir_nec_receiver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared types and NEC pulse-timing constants for the IR receiver.
// All durations are in microseconds and are scaled to clock ticks at elaboration.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_MARK,
    START_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } nec_state_t;

  localparam int unsigned START_MARK_MIN_US  = 8000;
  localparam int unsigned START_MARK_MAX_US  = 10000;
  localparam int unsigned START_SPACE_MIN_US = 4000;
  localparam int unsigned START_SPACE_MAX_US = 5000;
  localparam int unsigned REPEAT_MIN_US      = 2000;
  localparam int unsigned REPEAT_MAX_US      = 2500;
  localparam int unsigned MARK_MIN_US        = 400;
  localparam int unsigned MARK_MAX_US        = 750;
  localparam int unsigned BIT_ONE_US         = 1125;
  localparam int unsigned SPACE_MAX_US       = 2000;

  // Truncating conversion; 64-bit intermediate keeps large clock ratios exact.
  function automatic int unsigned us_to_ticks(input int unsigned us,
                                              input int unsigned mult,
                                              input int unsigned div);
    longint unsigned t;
    t = (longint'(us) * longint'(mult)) / longint'(div);
    return t[31:0];
  endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer for the raw IR level with single-cycle rise/fall pulses.
// Flops reset to 1 so the idle-high line does not produce a false edge after reset.
module ir_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  // [0] first stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], din};
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC infrared frame decoder: measures mark/space widths between synchronized edges,
// shifts in 2*(address+data) bits LSB first and latches fields when complements match.
module ir_nec_receiver
  import ir_nec_pkg::*;
#(
  parameter int unsigned multiplier    = 48,
  parameter int unsigned divider       = 1,
  parameter int unsigned counter_width = 20,
  parameter int unsigned address_width = 8,
  parameter int unsigned data_width    = 8
) (
  output logic [address_width-1:0] address,
  output logic [data_width-1:0]    data,
  output logic                     data_ready,
  input  logic                     ir,
  input  logic                     enable,
  input  logic                     clk,
  input  logic                     reset
);

  localparam int unsigned FRAME_BITS = 2 * (address_width + data_width);
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS + 1);

  localparam logic [counter_width-1:0] T_START_MARK_MIN  = counter_width'(us_to_ticks(START_MARK_MIN_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_START_MARK_MAX  = counter_width'(us_to_ticks(START_MARK_MAX_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_START_SPACE_MIN = counter_width'(us_to_ticks(START_SPACE_MIN_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_START_SPACE_MAX = counter_width'(us_to_ticks(START_SPACE_MAX_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_REPEAT_MIN      = counter_width'(us_to_ticks(REPEAT_MIN_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_REPEAT_MAX      = counter_width'(us_to_ticks(REPEAT_MAX_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_MARK_MIN        = counter_width'(us_to_ticks(MARK_MIN_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_MARK_MAX        = counter_width'(us_to_ticks(MARK_MAX_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_BIT_ONE         = counter_width'(us_to_ticks(BIT_ONE_US, multiplier, divider));
  localparam logic [counter_width-1:0] T_SPACE_MAX       = counter_width'(us_to_ticks(SPACE_MAX_US, multiplier, divider));

  logic                     ir_rise, ir_fall;
  logic [counter_width-1:0] tick_cnt;
  logic                     saturated;
  nec_state_t               state, state_next;
  logic [FRAME_BITS-1:0]    shift_reg;
  logic [IDX_W-1:0]         bit_idx;
  logic                     shift_en, shift_bit, idx_clr, frame_done, frame_ok;
  logic [address_width-1:0] addr_f, addr_n;
  logic [data_width-1:0]    data_f, data_n;

  ir_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ir),
    .rise  (ir_rise),
    .fall  (ir_fall)
  );

  function automatic logic in_range(input logic [counter_width-1:0] v,
                                    input logic [counter_width-1:0] lo,
                                    input logic [counter_width-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  tick_cnt <= '0;
    else if (ir_rise | ir_fall) tick_cnt <= '0;
    else if (!saturated)        tick_cnt <= tick_cnt + 1'b1;
  end

  assign saturated = &tick_cnt;

  // Shift is LSB-first from the top, so after a full frame bit 0 holds the first bit received.
  assign addr_f   = shift_reg[address_width-1:0];
  assign addr_n   = shift_reg[2*address_width-1:address_width];
  assign data_f   = shift_reg[2*address_width +: data_width];
  assign data_n   = shift_reg[2*address_width+data_width +: data_width];
  assign frame_ok = (addr_n == ~addr_f) && (data_n == ~data_f);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    shift_bit  = 1'b0;
    idx_clr    = 1'b0;
    frame_done = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ir_fall) state_next = START_MARK;
        end
        START_MARK: begin
          if (ir_rise)
            state_next = in_range(tick_cnt, T_START_MARK_MIN, T_START_MARK_MAX) ? START_SPACE : IDLE;
          else if (saturated)
            state_next = IDLE;
        end
        START_SPACE: begin
          if (ir_fall) begin
            if (in_range(tick_cnt, T_START_SPACE_MIN, T_START_SPACE_MAX)) begin
              state_next = BIT_MARK;
              idx_clr    = 1'b1;
            end else if (in_range(tick_cnt, T_REPEAT_MIN, T_REPEAT_MAX)) begin
              state_next = IDLE;  // repeat code carries no new fields
            end else begin
              state_next = IDLE;
            end
          end else if (saturated) begin
            state_next = IDLE;
          end
        end
        BIT_MARK: begin
          if (ir_rise)
            state_next = in_range(tick_cnt, T_MARK_MIN, T_MARK_MAX) ? BIT_SPACE : IDLE;
          else if (saturated)
            state_next = IDLE;
        end
        BIT_SPACE: begin
          if (ir_fall) begin
            if (in_range(tick_cnt, T_MARK_MIN, T_SPACE_MAX)) begin
              shift_en   = 1'b1;
              shift_bit  = (tick_cnt >= T_BIT_ONE);
              state_next = (bit_idx == IDX_W'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
            end else begin
              state_next = IDLE;
            end
          end else if (tick_cnt > T_SPACE_MAX) begin
            state_next = IDLE;
          end
        end
        STOP_MARK: begin
          if (ir_rise) begin
            frame_done = in_range(tick_cnt, T_MARK_MIN, T_MARK_MAX) && frame_ok;
            state_next = IDLE;
          end else if (saturated) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else if (!enable) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      if (idx_clr)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + IDX_W'(1);
      if (shift_en)
        shift_reg <= {shift_bit, shift_reg[FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address    <= '0;
      data       <= '0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= frame_done;
      if (frame_done) begin
        address <= addr_f;
        data    <= data_f;
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Randomized frame-level bench for ir_nec_receiver; one clock tick is 20 us
// (multiplier=1, divider=20) so that a full NEC frame is a few thousand cycles.
`timescale 1ns/1ps
module tb_ir_nec_receiver;

  localparam int TICK_US = 20;
  localparam int START_C = 9000 / TICK_US;
  localparam int SPACE_C = 4500 / TICK_US;
  localparam int REPT_C  = 2250 / TICK_US;
  localparam int SHORT_C = 5000 / TICK_US;
  localparam int MARK_C  = 562 / TICK_US;
  localparam int ZERO_C  = 562 / TICK_US;
  localparam int ONE_C   = 1687 / TICK_US;
  localparam int GAP_C   = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       ir;
  logic       enable;
  logic [7:0] address, data;
  logic       data_ready;

  ir_nec_receiver #(
    .multiplier(1), .divider(20), .counter_width(16),
    .address_width(8), .data_width(8)
  ) dut (
    .address    (address),
    .data       (data),
    .data_ready (data_ready),
    .ir         (ir),
    .enable     (enable),
    .clk        (clk),
    .reset      (reset)
  );

  always #10000 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int stop_rise_cyc = 0;
  logic [7:0] pulse_addr = '0, pulse_data = '0;
  logic [7:0] exp_addr = '0, exp_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_ready) begin
      pulse_cnt  = pulse_cnt + 1;
      pulse_cyc  = cyc;
      pulse_addr = address;
      pulse_data = data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    @(negedge clk);
    ir = lvl;
    repeat (n - 1) @(negedge clk);
  endtask

  // Reference: a frame is accepted only if every spec rule holds at the microsecond level.
  function automatic bit frame_valid(input int start_c, input int space_c,
                                     input logic [7:0] a, ac, d, dc,
                                     input bit en, input bit rst_mid);
    int start_us, space_us;
    start_us = start_c * TICK_US;
    space_us = space_c * TICK_US;
    return en && !rst_mid &&
           start_us >= 8000 && start_us <= 10000 &&
           space_us >= 4000 && space_us <= 5000 &&
           ac == ~a && dc == ~d;
  endfunction

  task automatic send_frame(input logic [7:0] a, ac, d, dc,
                            input int start_c, input int space_c, input int rst_bit);
    logic [31:0] w;
    w = {dc, d, ac, a};
    drive(1'b0, start_c);
    drive(1'b1, space_c);
    for (int i = 0; i < 32; i++) begin
      if (i == rst_bit) begin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end
      drive(1'b0, MARK_C);
      drive(1'b1, w[i] ? ONE_C : ZERO_C);
    end
    drive(1'b0, MARK_C);
    @(negedge clk);
    ir = 1'b1;
    stop_rise_cyc = cyc;
    repeat (GAP_C - 1) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a, ac, d, dc,
                           input int start_c, input int rst_bit);
    int  p0;
    bit  good;
    p0   = pulse_cnt;
    good = frame_valid(start_c, SPACE_C, a, ac, d, dc, enable, rst_bit >= 0);
    send_frame(a, ac, d, dc, start_c, SPACE_C, rst_bit);
    if (rst_bit >= 0) begin
      exp_addr = '0;
      exp_data = '0;
    end
    if (good) begin
      exp_addr = a;
      exp_data = d;
    end
    chk({tag, " pulses"}, pulse_cnt - p0, good ? 1 : 0);
    chk({tag, " address"}, address, exp_addr);
    chk({tag, " data"}, data, exp_data);
    if (good) begin
      chk({tag, " latency"}, pulse_cyc - stop_rise_cyc, 3);
      chk({tag, " addr@pulse"}, pulse_addr, a);
      chk({tag, " data@pulse"}, pulse_data, d);
    end
  endtask

  initial begin
    logic [7:0] a, d, ac, dc;
    int mode, st, p0;

    reset  = 1'b1;
    ir     = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset address", address, 8'h00);
    chk("reset data", data, 8'h00);
    chk("reset data_ready", data_ready, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    run_frame("basic", 8'h00, 8'hFF, 8'h42, 8'hBD, START_C, -1);
    run_frame("bad_cmpl", 8'h00, 8'hFF, 8'h42, 8'hBC, START_C, -1);
    run_frame("short_start", 8'h5A, 8'hA5, 8'h3C, 8'hC3, SHORT_C, -1);
    run_frame("after_short", 8'h5A, 8'hA5, 8'h3C, 8'hC3, START_C, -1);

    p0 = pulse_cnt;
    drive(1'b0, START_C);
    drive(1'b1, REPT_C);
    drive(1'b0, MARK_C);
    drive(1'b1, GAP_C);
    chk("repeat pulses", pulse_cnt - p0, 0);
    chk("repeat address", address, exp_addr);
    chk("repeat data", data, exp_data);

    run_frame("reset_mid", 8'h11, 8'hEE, 8'h22, 8'hDD, START_C, 10);
    run_frame("post_reset", 8'hA5, 8'h5A, 8'h81, 8'h7E, START_C, -1);

    enable = 1'b0;
    run_frame("disabled", 8'h33, 8'hCC, 8'hCC, 8'h33, START_C, -1);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    run_frame("enabled", 8'h33, 8'hCC, 8'hCC, 8'h33, START_C, -1);

    for (int k = 0; k < 5; k++) begin
      a    = 8'($urandom);
      d    = 8'($urandom);
      ac   = ~a;
      dc   = ~d;
      mode = $urandom_range(0, 4);
      if (mode == 2) ac = ac ^ 8'(1 << $urandom_range(0, 7));
      if (mode == 3) dc = dc ^ 8'(1 << $urandom_range(0, 7));
      st = (mode == 4) ? SHORT_C : START_C;
      run_frame("random", a, ac, d, dc, st, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
